// File: rtl/frame_timing_pkg.sv
// Shared types and default widths for the frame timing monitor.
//   state_e        : monitor FSM states
//   DEF_CNT_W      : default cycle-counter width
//   DEF_PRI_CNT_W  : default PRI-per-frame counter width
//   FRAME_COUNT_W  : width of the completed-frame counter
package frame_timing_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_IN_FRAME
  } state_e;

  localparam int unsigned DEF_CNT_W     = 32;
  localparam int unsigned DEF_PRI_CNT_W = 16;
  localparam int unsigned FRAME_COUNT_W = 16;

endpackage

// File: rtl/pulse_edge_detect.sv
// Single-bit rising-edge detector.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   sig_in : level input
//   rise   : high while sig_in is 1 and was 0 at the previous edge
// The history register resets to 1, so an input already high when reset
// releases does not produce a spurious event.
module pulse_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic hist_q;
  logic hist_d;

  always_comb hist_d = sig_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist_q <= 1'b1;
    else        hist_q <= hist_d;
  end

  assign rise = sig_in & ~hist_q;

endmodule

// File: rtl/frame_timing_monitor.sv
// Receive-side checker for the radar frame timing generator.
// Inputs : clk, reset (async active-low), start_of_frame,
//          pulse_repetition_interval, end_of_frame, clear_errors
// Outputs: frame_done (1-cycle pulse), frame_ok, pri_count, last_pri_period,
//          frame_length, frame_count, sticky err_period/err_count/err_sequence
module frame_timing_monitor
  import frame_timing_pkg::*;
#(
  parameter int unsigned CNT_W              = DEF_CNT_W,
  parameter int unsigned PRI_CNT_W          = DEF_PRI_CNT_W,
  parameter int unsigned EXP_PRI_PERIOD     = 1000,
  parameter int unsigned PERIOD_TOL         = 0,
  parameter int unsigned EXP_PRIS_PER_FRAME = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_of_frame,
  input  logic                     pulse_repetition_interval,
  input  logic                     end_of_frame,
  input  logic                     clear_errors,
  output logic                     frame_done,
  output logic                     frame_ok,
  output logic [PRI_CNT_W-1:0]     pri_count,
  output logic [CNT_W-1:0]         last_pri_period,
  output logic [CNT_W-1:0]         frame_length,
  output logic [FRAME_COUNT_W-1:0] frame_count,
  output logic                     err_period,
  output logic                     err_count,
  output logic                     err_sequence
);

  localparam logic [CNT_W:0]       EXP_PERIOD_X = (CNT_W+1)'(EXP_PRI_PERIOD);
  localparam logic [CNT_W:0]       TOL_X        = (CNT_W+1)'(PERIOD_TOL);
  localparam logic [PRI_CNT_W-1:0] EXP_CNT      = PRI_CNT_W'(EXP_PRIS_PER_FRAME);

  logic sof_ev, pri_ev, eof_ev;

  pulse_edge_detect u_sof_det (.clk(clk), .reset(reset), .sig_in(start_of_frame),            .rise(sof_ev));
  pulse_edge_detect u_pri_det (.clk(clk), .reset(reset), .sig_in(pulse_repetition_interval), .rise(pri_ev));
  pulse_edge_detect u_eof_det (.clk(clk), .reset(reset), .sig_in(end_of_frame),              .rise(eof_ev));

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         frame_cyc_q, frame_cyc_d;
  logic [CNT_W-1:0]         pri_timer_q, pri_timer_d;
  logic [PRI_CNT_W-1:0]     cur_pri_q, cur_pri_d;
  logic                     first_pri_q, first_pri_d;
  logic                     frame_err_q, frame_err_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_ok_q, frame_ok_d;
  logic [PRI_CNT_W-1:0]     pri_count_q, pri_count_d;
  logic [CNT_W-1:0]         last_pri_period_q, last_pri_period_d;
  logic [CNT_W-1:0]         frame_length_q, frame_length_d;
  logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
  logic                     err_period_q, err_period_d;
  logic                     err_count_q, err_count_d;
  logic                     err_sequence_q, err_sequence_d;

  logic [CNT_W-1:0]     frame_cyc_inc, pri_period;
  logic [PRI_CNT_W-1:0] cur_pri_inc;
  logic [CNT_W:0]       period_ext, period_dev;
  logic                 period_out_of_tol;

  assign frame_cyc_inc = (&frame_cyc_q) ? frame_cyc_q : frame_cyc_q + CNT_W'(1);
  assign pri_period    = (&pri_timer_q) ? pri_timer_q : pri_timer_q + CNT_W'(1);
  assign cur_pri_inc   = (&cur_pri_q)   ? cur_pri_q   : cur_pri_q + PRI_CNT_W'(1);

  // One extra bit so the absolute deviation never wraps.
  assign period_ext        = {1'b0, pri_period};
  assign period_dev        = (period_ext >= EXP_PERIOD_X) ? period_ext - EXP_PERIOD_X
                                                          : EXP_PERIOD_X - period_ext;
  assign period_out_of_tol = period_dev > TOL_X;

  logic pri_old, open_frame, period_bad, count_bad;
  logic set_period, set_count, set_seq;
  logic [PRI_CNT_W-1:0] close_pri;

  always_comb begin
    state_d           = state_q;
    frame_cyc_d       = frame_cyc_q;
    pri_timer_d       = pri_timer_q;
    cur_pri_d         = cur_pri_q;
    first_pri_d       = first_pri_q;
    frame_err_d       = frame_err_q;
    frame_done_d      = 1'b0;
    frame_ok_d        = frame_ok_q;
    pri_count_d       = pri_count_q;
    last_pri_period_d = last_pri_period_q;
    frame_length_d    = frame_length_q;
    frame_count_d     = frame_count_q;
    pri_old           = 1'b0;
    open_frame        = 1'b0;
    period_bad        = 1'b0;
    count_bad         = 1'b0;
    close_pri         = cur_pri_q;
    set_period        = 1'b0;
    set_count         = 1'b0;
    set_seq           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((pri_ev && !sof_ev) || eof_ev) set_seq = 1'b1;
        if (sof_ev) open_frame = 1'b1;
      end
      ST_IN_FRAME: begin
        // A PRI belongs to the running frame unless a lone SOF restarts it
        // on the same edge; with SOF+EOF the closing frame takes the PRI.
        pri_old     = pri_ev && (!sof_ev || eof_ev);
        frame_cyc_d = frame_cyc_inc;
        pri_timer_d = pri_period;
        if (pri_old) begin
          cur_pri_d   = cur_pri_inc;
          close_pri   = cur_pri_inc;
          pri_timer_d = '0;
          first_pri_d = 1'b0;
          if (!first_pri_q) begin
            last_pri_period_d = pri_period;
            if (period_out_of_tol) begin
              period_bad  = 1'b1;
              set_period  = 1'b1;
              frame_err_d = 1'b1;
            end
          end
        end
        if (eof_ev) begin
          count_bad      = (close_pri != EXP_CNT);
          frame_length_d = frame_cyc_inc;
          pri_count_d    = close_pri;
          frame_done_d   = 1'b1;
          frame_count_d  = frame_count_q + FRAME_COUNT_W'(1);
          frame_ok_d     = !(frame_err_q || period_bad) && !count_bad;
          set_count      = count_bad;
          state_d        = ST_IDLE;
        end else if (sof_ev) begin
          set_seq = 1'b1;
        end
        if (sof_ev) open_frame = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (open_frame) begin
      state_d     = ST_IN_FRAME;
      frame_cyc_d = '0;
      pri_timer_d = '0;
      frame_err_d = 1'b0;
      if (pri_ev && !pri_old) begin
        cur_pri_d   = PRI_CNT_W'(1);
        first_pri_d = 1'b0;
      end else begin
        cur_pri_d   = '0;
        first_pri_d = 1'b1;
      end
    end
  end

  // Set takes priority over a same-edge clear.
  assign err_period_d   = set_period | (err_period_q   & ~clear_errors);
  assign err_count_d    = set_count  | (err_count_q    & ~clear_errors);
  assign err_sequence_d = set_seq    | (err_sequence_q & ~clear_errors);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      frame_cyc_q       <= '0;
      pri_timer_q       <= '0;
      cur_pri_q         <= '0;
      first_pri_q       <= 1'b0;
      frame_err_q       <= 1'b0;
      frame_done_q      <= 1'b0;
      frame_ok_q        <= 1'b0;
      pri_count_q       <= '0;
      last_pri_period_q <= '0;
      frame_length_q    <= '0;
      frame_count_q     <= '0;
      err_period_q      <= 1'b0;
      err_count_q       <= 1'b0;
      err_sequence_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      frame_cyc_q       <= frame_cyc_d;
      pri_timer_q       <= pri_timer_d;
      cur_pri_q         <= cur_pri_d;
      first_pri_q       <= first_pri_d;
      frame_err_q       <= frame_err_d;
      frame_done_q      <= frame_done_d;
      frame_ok_q        <= frame_ok_d;
      pri_count_q       <= pri_count_d;
      last_pri_period_q <= last_pri_period_d;
      frame_length_q    <= frame_length_d;
      frame_count_q     <= frame_count_d;
      err_period_q      <= err_period_d;
      err_count_q       <= err_count_d;
      err_sequence_q    <= err_sequence_d;
    end
  end

  assign frame_done      = frame_done_q;
  assign frame_ok        = frame_ok_q;
  assign pri_count       = pri_count_q;
  assign last_pri_period = last_pri_period_q;
  assign frame_length    = frame_length_q;
  assign frame_count     = frame_count_q;
  assign err_period      = err_period_q;
  assign err_count       = err_count_q;
  assign err_sequence    = err_sequence_q;

endmodule
